// File: rtl/sr_cmd_if.sv
// Command/feedback bundle between a requester and the SR flip-flop driver.
// The slave side is the driver; the master side is the requester plus the flip-flop feedback.
interface sr_cmd_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       q_fb;
  logic       qbar_fb;
  logic       s;
  logic       r;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output cmd_valid, cmd_op, q_fb, qbar_fb,
    input  cmd_ready, s, r, busy, done, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_op, q_fb, qbar_fb,
    output cmd_ready, s, r, busy, done, err, err_code
  );
endinterface

// File: rtl/sr_cmd_driver.sv
// Drives an external SR flip-flop with one-cycle set/reset pulses and
// confirms the result through its q/qbar feedback, reporting done or err.
module sr_cmd_driver #(
  parameter int SETTLE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  sr_cmd_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  localparam logic [1:0] EC_NONE    = 2'b00;
  localparam logic [1:0] EC_TIMEOUT = 2'b01;
  localparam logic [1:0] EC_ILLEGAL = 2'b10;

  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_MAX);

  state_t     state;
  logic       target;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic       next_target;
  logic       s_q;
  logic       r_q;
  logic       done_q;
  logic       err_q;
  logic [1:0] err_code_q;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    cnt_inc = sat_inc4(cnt);
    case (bus.cmd_op)
      OP_CLEAR: next_target = 1'b0;
      OP_SET:   next_target = 1'b1;
      default:  next_target = ~bus.q_fb;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      target     <= 1'b0;
      cnt        <= 4'd0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= EC_NONE;
    end else begin
      // Pulse outputs are 0 unless the transition below raises them.
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_op == OP_NOP) begin
              state  <= RESP;
              done_q <= 1'b1;
            end else begin
              state      <= DRIVE;
              target     <= next_target;
              cnt        <= 4'd0;
              err_code_q <= EC_NONE;
              // s and r come from one bit and its complement, so they can never both be 1.
              s_q        <= next_target;
              r_q        <= ~next_target;
            end
          end
        end
        DRIVE: state <= WAIT;
        WAIT: begin
          cnt <= cnt_inc;
          if (bus.q_fb == bus.qbar_fb) begin
            state      <= RESP;
            err_q      <= 1'b1;
            err_code_q <= EC_ILLEGAL;
          end else if (bus.q_fb == target) begin
            state  <= RESP;
            done_q <= 1'b1;
          end else if (cnt_inc >= SETTLE_LIM) begin
            state      <= RESP;
            err_q      <= 1'b1;
            err_code_q <= EC_TIMEOUT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Bench for sr_cmd_driver: SR flip-flop model on the feedback path, scoreboard of
// predicted done/err outcomes, directed scenarios and a random command stream.
module tb_sr_cmd_driver;
  localparam int SETTLE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sr_cmd_if bus ();

  sr_cmd_driver #(.SETTLE_MAX(SETTLE_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Feedback: 0 = real flip-flop, 1 = q stuck at 1, 2 = illegal q=qbar=1
  int   mode = 0;
  logic q_mdl;
  always @(posedge clk or posedge rst) begin
    if (rst)        q_mdl <= 1'b0;
    else if (bus.s) q_mdl <= 1'b1;
    else if (bus.r) q_mdl <= 1'b0;
  end
  assign bus.q_fb    = (mode == 0) ? q_mdl : 1'b1;
  assign bus.qbar_fb = (mode == 0) ? ~q_mdl : (mode == 2);

  int errors = 0;
  int checks = 0;
  logic [3:0] sb[$];
  logic [1:0] exp_code = 2'b00;
  int s_cnt, r_cnt, acc_cnt, resp_cnt, tick_no, last_acc, prev_acc;
  logic resp_seen;

  task automatic monitor();
    logic [3:0] e;
    logic       tgt;
    logic       ok;
    checks++;
    if (bus.s && bus.r) begin
      errors++;
      $display("FAIL s_r_exclusive: s=%b r=%b, required not both 1", bus.s, bus.r);
    end
    checks++;
    if (bus.busy !== ~bus.cmd_ready) begin
      errors++;
      $display("FAIL busy_ready: busy=%b cmd_ready=%b, required busy=~cmd_ready", bus.busy, bus.cmd_ready);
    end
    if (bus.s) s_cnt++;
    if (bus.r) r_cnt++;
    resp_seen = bus.done || bus.err;
    if (resp_seen) begin
      resp_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: done=%b err=%b with no command outstanding", bus.done, bus.err);
      end else begin
        e = sb.pop_front();
        if ({bus.done, bus.err, bus.err_code} !== e) begin
          errors++;
          $display("FAIL resp: got done=%b err=%b code=%b, expected done=%b err=%b code=%b",
                   bus.done, bus.err, bus.err_code, e[3], e[2], e[1:0]);
        end
      end
    end
    if (!rst && bus.cmd_valid && bus.cmd_ready) begin
      acc_cnt++;
      prev_acc = last_acc;
      last_acc = tick_no;
      if (bus.cmd_op == 2'b00) begin
        sb.push_back({2'b10, exp_code});
      end else begin
        tgt = (bus.cmd_op == 2'b01) ? 1'b0 : (bus.cmd_op == 2'b10) ? 1'b1 : ~bus.q_fb;
        ok  = 1'b1;
        exp_code = 2'b00;
        if (mode == 2) begin
          ok = 1'b0; exp_code = 2'b10;
        end else if (mode == 1 && !tgt) begin
          ok = 1'b0; exp_code = 2'b01;
        end
        sb.push_back({ok, ~ok, exp_code});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tick_no++;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    resp_seen = 1'b0;
    while (!resp_seen && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!resp_seen) begin
      errors++;
      checks++;
      $display("FAIL resp_timeout: no done/err within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.s, bus.r, bus.done, bus.err, bus.busy, bus.cmd_ready, bus.err_code} !== 8'b0000_0100) begin
      errors++;
      $display("FAIL reset_outputs: s,r,done,err,busy,ready,code=%b, required 00000100",
               {bus.s, bus.r, bus.done, bus.err, bus.busy, bus.cmd_ready, bus.err_code});
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_set();
    int cyc;
    s_cnt = 0; r_cnt = 0;
    send(2'b10);
    wait_resp(cyc);
    checks++;
    if (cyc != 3 || s_cnt != 1 || r_cnt != 0 || q_mdl !== 1'b1 || bus.err_code !== 2'b00 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL set: lat=%0d s=%0d r=%0d q=%b code=%b ready=%b, required 3 1 0 1 00 1",
               cyc, s_cnt, r_cnt, q_mdl, bus.err_code, bus.cmd_ready);
    end
  endtask

  task automatic test_toggle();
    int cyc;
    s_cnt = 0; r_cnt = 0;
    send(2'b11);
    wait_resp(cyc);
    checks++;
    if (cyc != 3 || s_cnt != 0 || r_cnt != 1 || q_mdl !== 1'b0) begin
      errors++;
      $display("FAIL toggle_to_0: lat=%0d s=%0d r=%0d q=%b, required 3 0 1 0", cyc, s_cnt, r_cnt, q_mdl);
    end
    s_cnt = 0; r_cnt = 0;
    send(2'b11);
    wait_resp(cyc);
    checks++;
    if (cyc != 3 || s_cnt != 1 || r_cnt != 0 || q_mdl !== 1'b1) begin
      errors++;
      $display("FAIL toggle_to_1: lat=%0d s=%0d r=%0d q=%b, required 3 1 0 1", cyc, s_cnt, r_cnt, q_mdl);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    mode = 1;
    send(2'b01);
    wait_resp(cyc);
    checks++;
    if (cyc != SETTLE_MAX + 2 || bus.err_code !== 2'b01 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout: lat=%0d code=%b ready=%b, required %0d 01 1", cyc, bus.err_code, bus.cmd_ready, SETTLE_MAX + 2);
    end
    mode = 0;
  endtask

  task automatic test_illegal();
    int cyc;
    mode = 2;
    send(2'b10);
    wait_resp(cyc);
    checks++;
    if (cyc != 3 || bus.err_code !== 2'b10) begin
      errors++;
      $display("FAIL illegal_fb: lat=%0d code=%b, required 3 10", cyc, bus.err_code);
    end
    mode = 0;
  endtask

  task automatic test_nop_hold();
    int cyc;
    s_cnt = 0; r_cnt = 0;
    send(2'b00);
    wait_resp(cyc);
    checks++;
    if (cyc != 1 || s_cnt + r_cnt != 0 || bus.err_code !== 2'b10) begin
      errors++;
      $display("FAIL nop_hold: lat=%0d pulses=%0d code=%b, required 1 0 10", cyc, s_cnt + r_cnt, bus.err_code);
    end
    send(2'b01);
    wait_resp(cyc);
    checks++;
    if (bus.err_code !== 2'b00 || q_mdl !== 1'b0) begin
      errors++;
      $display("FAIL clear_after_err: code=%b q=%b, required 00 0", bus.err_code, q_mdl);
    end
  endtask

  task automatic test_reset_mid_drive();
    int cyc;
    int acc0;
    send(2'b10);
    checks++;
    if (bus.s !== 1'b1) begin
      errors++;
      $display("FAIL drive_before_rst: s=%b, required 1", bus.s);
    end
    #2 rst = 1'b1;
    #1;
    sb.delete();
    exp_code = 2'b00;
    checks++;
    if ({bus.s, bus.r, bus.done, bus.err, bus.cmd_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL rst_abort: s,r,done,err,ready=%b, required 00001", {bus.s, bus.r, bus.done, bus.err, bus.cmd_ready});
    end
    tick();
    tick();
    rst = 1'b0;
    acc0 = acc_cnt;
    s_cnt = 0;
    send(2'b10);
    wait_resp(cyc);
    checks++;
    if (acc_cnt - acc0 != 1 || cyc != 3 || s_cnt != 1 || q_mdl !== 1'b1) begin
      errors++;
      $display("FAIL set_after_rst: acc=%0d lat=%0d s=%0d q=%b, required 1 3 1 1", acc_cnt - acc0, cyc, s_cnt, q_mdl);
    end
  endtask

  task automatic test_back_to_back();
    int acc0;
    acc0 = acc_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    tick();
    bus.cmd_op = 2'b01;
    repeat (7) tick();
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (acc_cnt - acc0 != 2 || last_acc - prev_acc != 4 || q_mdl !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: accepts=%0d gap=%0d q=%b pending=%0d, required 2 4 0 0",
               acc_cnt - acc0, last_acc - prev_acc, q_mdl, sb.size());
    end
  endtask

  task automatic test_random();
    int acc0;
    int resp0;
    acc0 = acc_cnt;
    resp0 = resp_cnt;
    for (int i = 0; i < 10000; i++) begin
      if (bus.cmd_ready && $urandom_range(0, 7) == 0) begin
        bus.cmd_valid = 1'b0;
        mode = int'($urandom_range(0, 2));
      end else begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 2'($urandom_range(0, 3));
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    mode = 0;
    repeat (20) tick();
    checks++;
    if (acc_cnt - acc0 != resp_cnt - resp0 || sb.size() != 0 || acc_cnt - acc0 < 100) begin
      errors++;
      $display("FAIL random: accepts=%0d responses=%0d pending=%0d", acc_cnt - acc0, resp_cnt - resp0, sb.size());
    end
  endtask

  initial begin
    s_cnt = 0; r_cnt = 0; acc_cnt = 0; resp_cnt = 0; tick_no = 0; last_acc = 0; prev_acc = 0;
    resp_seen = 1'b0;
    test_reset();
    test_set();
    test_toggle();
    test_timeout();
    test_illegal();
    test_nop_hold();
    test_reset_mid_drive();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
